// File: rtl/stream_register_master_pkg.sv
// Shared constants and FSM encoding for the byte-stream register bus initiator.
// Request sync/command codes, response sync byte, parser/bus/response states.
package stream_register_master_pkg;

  localparam logic [7:0] SYNC_REQ  = 8'h55;
  localparam logic [7:0] SYNC_RSP  = 8'hAA;
  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef enum logic [3:0] {
    stIdle,
    stCmd,
    stAddr,
    stWrData,
    stWrStrobe,
    stRdWait,
    stTxHeader,
    stTxAddr,
    stTxData
  } stateT;

endpackage

// File: rtl/stream_register_master_response_serialiser.sv
// Read-response serialiser: loads address and data, then emits AA, address and
// four little-endian data bytes under valid/ready, pulsing done on the last byte.
module stream_register_master_response_serialiser
  import stream_register_master_pkg::*;
(
  input  logic        ipClk,
  input  logic        Reset,
  input  logic        load,
  input  logic [7:0]  address,
  input  logic [31:0] data,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic        done
);

  logic [47:0] shiftReg;
  logic [2:0]  byteIdx;

  // The outgoing byte is always the low byte of the buffer, so it only moves on a transfer.
  assign opTxData = shiftReg[7:0];
  assign done     = opTxValid & ipTxReady & (byteIdx == 3'd5);

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      shiftReg  <= '0;
      byteIdx   <= '0;
      opTxValid <= 1'b0;
    end else if (load) begin
      shiftReg  <= {data, address, SYNC_RSP};
      byteIdx   <= '0;
      opTxValid <= 1'b1;
    end else if (opTxValid && ipTxReady) begin
      shiftReg <= {8'h00, shiftReg[47:8]};
      byteIdx  <= byteIdx + 3'd1;
      if (byteIdx == 3'd5) begin
        opTxValid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_register_master.sv
// Byte-stream command parser driving single register writes/reads on an
// 8-bit address / 32-bit data bus, with serialised read responses.
module stream_register_master
  import stream_register_master_pkg::*;
#(
  parameter int TIMEOUT    = 50000,
  parameter int RD_LATENCY = 1
) (
  input  logic        ipClk,
  input  logic        Reset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData,
  output logic        opBusy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(RD_LATENCY + 1) + 1;

  stateT         state;
  logic          isWrite;
  logic [1:0]    byteCnt;
  logic [TW-1:0] idleCnt;
  logic [LW-1:0] latCnt;
  logic          inParse;
  logic          expired;
  logic          rxSync;
  logic          rspLoad;
  logic          rspDone;
  logic          txFire;

  assign inParse = state inside {stCmd, stAddr, stWrData};
  assign expired = inParse && (idleCnt == TW'(TIMEOUT));
  assign rxSync  = ipRxValid && (ipRxData == SYNC_REQ);
  // Read data is taken after RD_LATENCY+1 cycles of a stable address.
  assign rspLoad = (state == stRdWait) && (latCnt == LW'(RD_LATENCY));
  assign txFire  = opTxValid && ipTxReady;

  stream_register_master_response_serialiser uSerialiser (
    .ipClk     (ipClk),
    .Reset     (Reset),
    .load      (rspLoad),
    .address   (opAddress),
    .data      (ipRdData),
    .opTxData  (opTxData),
    .opTxValid (opTxValid),
    .ipTxReady (ipTxReady),
    .done      (rspDone)
  );

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      state      <= stIdle;
      isWrite    <= 1'b0;
      byteCnt    <= '0;
      idleCnt    <= '0;
      latCnt     <= '0;
      opAddress  <= '0;
      opWrData   <= '0;
      opWrEnable <= 1'b0;
      opBusy     <= 1'b0;
    end else begin
      opWrEnable <= 1'b0;

      if (!inParse || ipRxValid || expired) begin
        idleCnt <= '0;
      end else begin
        idleCnt <= idleCnt + 1'b1;
      end

      // On expiry the partial packet is dropped and this cycle's byte is seen as Idle input.
      if (expired) begin
        state <= rxSync ? stCmd : stIdle;
      end else begin
        case (state)
          stIdle: begin
            if (rxSync) state <= stCmd;
          end
          stCmd: begin
            if (ipRxValid) begin
              if (ipRxData == CMD_READ) begin
                isWrite <= 1'b0;
                state   <= stAddr;
              end else if (ipRxData == CMD_WRITE) begin
                isWrite <= 1'b1;
                state   <= stAddr;
              end else begin
                state <= stIdle;
              end
            end
          end
          stAddr: begin
            if (ipRxValid) begin
              opAddress <= ipRxData;
              byteCnt   <= '0;
              latCnt    <= '0;
              if (isWrite) begin
                state <= stWrData;
              end else begin
                state  <= stRdWait;
                opBusy <= 1'b1;
              end
            end
          end
          stWrData: begin
            if (ipRxValid) begin
              opWrData <= {ipRxData, opWrData[31:8]};
              byteCnt  <= byteCnt + 2'd1;
              if (byteCnt == 2'd3) begin
                state      <= stWrStrobe;
                opWrEnable <= 1'b1;
                opBusy     <= 1'b1;
              end
            end
          end
          stWrStrobe: begin
            state  <= stIdle;
            opBusy <= 1'b0;
          end
          stRdWait: begin
            if (rspLoad) state <= stTxHeader;
            else latCnt <= latCnt + 1'b1;
          end
          stTxHeader: begin
            if (txFire) state <= stTxAddr;
          end
          stTxAddr: begin
            if (txFire) state <= stTxData;
          end
          stTxData: begin
            if (rspDone) begin
              state  <= stIdle;
              opBusy <= 1'b0;
            end
          end
          default: state <= stIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_register_master.sv
// Randomised bench for stream_register_master: a packet-level reference model
// predicts bus writes and response bytes, compared against monitored traffic.
module tb_stream_register_master;

  localparam int TIMEOUT = 20;

  logic        ipClk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  ipRxData = 8'h00;
  logic        ipRxValid = 1'b0;
  logic [7:0]  opTxData;
  logic        opTxValid;
  logic        ipTxReady;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic [31:0] ipRdData;
  logic        opBusy;

  int errors = 0;
  int checks = 0;

  int   readyMode = 0;    // 0: always ready, 1: random, 2: forced by readyForce
  logic readyForce = 1'b0;
  logic readyRand = 1'b1;
  assign ipTxReady = (readyMode == 1) ? readyRand : (readyMode == 2) ? readyForce : 1'b1;

  logic [31:0] regMem [256];
  logic [31:0] refMem [256];
  logic        memLoaded = 1'b0;
  logic [31:0] memSeed = 32'h0;

  logic [39:0] obsWr[$];
  logic [39:0] expWr[$];
  logic [7:0]  obsTx[$];
  logic [7:0]  expTx[$];

  stream_register_master #(.TIMEOUT(TIMEOUT), .RD_LATENCY(1)) dut (
    .ipClk      (ipClk),
    .Reset      (Reset),
    .ipRxData   (ipRxData),
    .ipRxValid  (ipRxValid),
    .opTxData   (opTxData),
    .opTxValid  (opTxValid),
    .ipTxReady  (ipTxReady),
    .opAddress  (opAddress),
    .opWrData   (opWrData),
    .opWrEnable (opWrEnable),
    .ipRdData   (ipRdData),
    .opBusy     (opBusy)
  );

  always #5 ipClk = ~ipClk;

  always @(negedge ipClk) readyRand = 1'($urandom_range(0, 1));

  function automatic logic [31:0] initWord(input int a);
    if (a == 1) return 32'h0000_000A;
    return memSeed ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  // Register block with one-cycle read latency, plus bus/stream monitors.
  always @(posedge ipClk) begin
    ipRdData <= regMem[opAddress];
    if (!memLoaded) begin
      for (int i = 0; i < 256; i++) regMem[i] <= initWord(i);
      memLoaded <= 1'b1;
    end else if (!Reset) begin
      if (opWrEnable) begin
        regMem[opAddress] <= opWrData;
        obsWr.push_back({opAddress, opWrData});
      end
      if (opTxValid && ipTxReady) obsTx.push_back(opTxData);
    end
  end

  task automatic clearQueues();
    obsWr.delete(); expWr.delete(); obsTx.delete(); expTx.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ipClk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge ipClk);
    ipRxData  = b;
    ipRxValid = 1'b1;
    @(negedge ipClk);
    ipRxValid = 1'b0;
  endtask

  task automatic sendPacket(input bit isWr, input logic [7:0] addr, input logic [31:0] data,
                            input int minGap, input int maxGap);
    logic [7:0] bytes[$];
    bytes.push_back(8'h55);
    bytes.push_back(isWr ? 8'h01 : 8'h00);
    bytes.push_back(addr);
    if (isWr) for (int i = 0; i < 4; i++) bytes.push_back(data[8*i +: 8]);
    for (int i = 0; i < bytes.size(); i++) begin
      sendByte(bytes[i]);
      if (i != bytes.size() - 1) idle(int'($urandom_range(maxGap, minGap)));
    end
  endtask

  // Reference model: a write updates the model memory, a read yields AA, addr, data LE.
  task automatic expectPacket(input bit isWr, input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] d;
    if (isWr) begin
      expWr.push_back({addr, data});
      refMem[addr] = data;
    end else begin
      d = refMem[addr];
      expTx.push_back(8'hAA);
      expTx.push_back(addr);
      for (int i = 0; i < 4; i++) expTx.push_back(d[8*i +: 8]);
    end
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (obsTx.size() < expTx.size() && n < 2000) begin
      @(negedge ipClk);
      n++;
    end
    idle(4);
    checks++;
    if (obsTx.size() < expTx.size()) begin
      errors++;
      $display("FAIL %s_tx_wait: got %0d bytes, required %0d", name, obsTx.size(), expTx.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle(3);
    checks++;
    if (opTxValid !== 1'b0 || opWrEnable !== 1'b0 || opBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: txValid=%b wrEn=%b busy=%b required 0 0 0", opTxValid, opWrEnable, opBusy);
    end
    checks++;
    if (opAddress !== 8'h00 || opWrData !== 32'h0 || opTxData !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: addr=%h wrData=%h txData=%h required 00 00000000 00", opAddress, opWrData, opTxData);
    end
    Reset = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    clearQueues();
    expectPacket(1, 8'h02, 32'hDEADBEEF);
    sendPacket(1, 8'h02, 32'hDEADBEEF, 0, 0);
    idle(6);
    checks++;
    if (obsWr.size() != 1) begin
      errors++;
      $display("FAIL write_count: got %0d strobes, required 1", obsWr.size());
    end
    if (obsWr.size() >= 1) begin
      checks++;
      if (obsWr[0] !== 40'h02_DEADBEEF) begin
        errors++;
        $display("FAIL write_value: got addr=%h data=%h required addr=02 data=deadbeef", obsWr[0][39:32], obsWr[0][31:0]);
      end
    end
    checks++;
    if (opAddress !== 8'h02 || opWrData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_hold: addr=%h data=%h required 02 deadbeef", opAddress, opWrData);
    end
    checks++;
    if (obsTx.size() != 0) begin
      errors++;
      $display("FAIL write_no_tx: got %0d tx bytes, required 0", obsTx.size());
    end
  endtask

  task automatic test_read();
    logic [7:0] want[6];
    want = '{8'hAA, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h00};
    clearQueues();
    readyMode = 0;
    sendPacket(0, 8'h01, 32'h0, 0, 0);
    expTx.push_back(8'h00); expTx.push_back(8'h00); expTx.push_back(8'h00);
    expTx.push_back(8'h00); expTx.push_back(8'h00); expTx.push_back(8'h00);
    waitDone("read");
    checks++;
    if (obsTx.size() != 6) begin
      errors++;
      $display("FAIL read_len: got %0d bytes, required 6", obsTx.size());
    end
    for (int i = 0; i < 6 && i < obsTx.size(); i++) begin
      checks++;
      if (obsTx[i] !== want[i]) begin
        errors++;
        $display("FAIL read_byte%0d: got %h required %h", i, obsTx[i], want[i]);
      end
    end
    checks++;
    if (obsWr.size() != 0) begin
      errors++;
      $display("FAIL read_no_write: got %0d strobes, required 0", obsWr.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a;
    int n;
    clearQueues();
    readyMode  = 2;
    readyForce = 1'b0;
    a = 8'($urandom_range(0, 255));
    expectPacket(0, a, 32'h0);
    sendPacket(0, a, 32'h0, 0, 3);
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (opTxValid !== 1'b1 && n < 50) begin
        @(negedge ipClk);
        n++;
      end
      checks++;
      if (opTxValid !== 1'b1) begin
        errors++;
        $display("FAIL bp_valid byte%0d: opTxValid=%b required 1", i, opTxValid);
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge ipClk);
        checks++;
        if (opTxValid !== 1'b1 || opTxData !== expTx[i] || opBusy !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold byte%0d cycle%0d: valid=%b data=%h busy=%b required 1 %h 1",
                   i, c, opTxValid, opTxData, opBusy, expTx[i]);
        end
      end
      readyForce = 1'b1;
      @(negedge ipClk);
      readyForce = 1'b0;
    end
    readyMode = 0;
    waitDone("bp");
    checks++;
    if (obsTx.size() != expTx.size()) begin
      errors++;
      $display("FAIL bp_len: got %0d bytes, required %0d", obsTx.size(), expTx.size());
    end
    for (int i = 0; i < expTx.size() && i < obsTx.size(); i++) begin
      checks++;
      if (obsTx[i] !== expTx[i]) begin
        errors++;
        $display("FAIL bp_byte%0d: got %h required %h", i, obsTx[i], expTx[i]);
      end
    end
    checks++;
    if (opTxValid !== 1'b0 || opBusy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: valid=%b busy=%b required 0 0", opTxValid, opBusy);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    clearQueues();
    // 21 idle clocks after a partial write: the packet must be discarded.
    sendByte(8'h55); sendByte(8'h01); sendByte(8'h02); sendByte(8'hEF);
    idle(20);
    idle(3);
    checks++;
    if (obsWr.size() != 0) begin
      errors++;
      $display("FAIL timeout_abort: got %0d strobes, required 0", obsWr.size());
    end
    // Longest tolerated gap (TIMEOUT-1 idle clocks) between every byte.
    d = $urandom;
    expectPacket(1, 8'h44, d);
    sendPacket(1, 8'h44, d, TIMEOUT - 2, TIMEOUT - 2);
    idle(6);
    // A sync byte landing exactly on expiry starts a fresh packet.
    sendByte(8'h55); sendByte(8'h01); sendByte(8'h05); sendByte(8'h11);
    idle(TIMEOUT - 1);
    d = $urandom;
    expectPacket(1, 8'h06, d);
    sendByte(8'h55); sendByte(8'h01); sendByte(8'h06);
    for (int i = 0; i < 4; i++) sendByte(d[8*i +: 8]);
    idle(6);
    checks++;
    if (obsWr.size() != expWr.size()) begin
      errors++;
      $display("FAIL timeout_count: got %0d strobes, required %0d", obsWr.size(), expWr.size());
    end
    for (int i = 0; i < expWr.size() && i < obsWr.size(); i++) begin
      checks++;
      if (obsWr[i] !== expWr[i]) begin
        errors++;
        $display("FAIL timeout_write%0d: got %h required %h", i, obsWr[i], expWr[i]);
      end
    end
  endtask

  task automatic test_junk();
    logic [7:0] junk[11];
    junk = '{8'h12, 8'h55, 8'h07, 8'h33, 8'h55, 8'h01, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00};
    clearQueues();
    for (int i = 0; i < 11; i++) sendByte(junk[i]);
    refMem[8'h03] = 32'h0000_0001;
    idle(6);
    checks++;
    if (obsWr.size() != 1) begin
      errors++;
      $display("FAIL junk_count: got %0d strobes, required 1", obsWr.size());
    end
    if (obsWr.size() >= 1) begin
      checks++;
      if (obsWr[0] !== 40'h03_00000001) begin
        errors++;
        $display("FAIL junk_write: got %h required 0300000001", obsWr[0]);
      end
    end
    checks++;
    if (obsTx.size() != 0) begin
      errors++;
      $display("FAIL junk_no_tx: got %0d tx bytes, required 0", obsTx.size());
    end
  endtask

  task automatic test_reset_mid_response();
    logic [7:0] a;
    int n;
    clearQueues();
    a = 8'($urandom_range(0, 255));
    readyMode  = 2;
    readyForce = 1'b1;
    sendPacket(0, a, 32'h0, 0, 0);
    n = 0;
    while (obsTx.size() < 2 && n < 100) begin
      @(negedge ipClk);
      n++;
    end
    readyForce = 1'b0;
    Reset = 1'b1;
    @(negedge ipClk);
    checks++;
    if (opTxValid !== 1'b0 || opBusy !== 1'b0 || opWrEnable !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: valid=%b busy=%b wrEn=%b required 0 0 0", opTxValid, opBusy, opWrEnable);
    end
    Reset = 1'b0;
    checks++;
    if (obsTx.size() != 2 || obsTx[0] !== 8'hAA || obsTx[1] !== a) begin
      errors++;
      $display("FAIL rstmid_partial: got %0d bytes, required 2 (AA %h)", obsTx.size(), a);
    end
    idle(3);
    clearQueues();
    readyMode = 0;
    a = 8'($urandom_range(0, 255));
    expectPacket(0, a, 32'h0);
    sendPacket(0, a, 32'h0, 0, 2);
    waitDone("rstmid");
    checks++;
    if (obsTx.size() != 6) begin
      errors++;
      $display("FAIL rstmid_len: got %0d bytes, required 6", obsTx.size());
    end
    for (int i = 0; i < expTx.size() && i < obsTx.size(); i++) begin
      checks++;
      if (obsTx[i] !== expTx[i]) begin
        errors++;
        $display("FAIL rstmid_byte%0d: got %h required %h", i, obsTx[i], expTx[i]);
      end
    end
  endtask

  task automatic test_random();
    bit          isWr;
    logic [7:0]  a;
    logic [31:0] d;
    clearQueues();
    readyMode = 1;
    for (int p = 0; p < 40; p++) begin
      isWr = 1'($urandom_range(0, 1));
      a    = 8'($urandom_range(0, 15));
      d    = $urandom;
      expectPacket(isWr, a, d);
      sendPacket(isWr, a, d, 0, 4);
      waitDone("rand");
      $display("packet %0d: %s addr=%h data=%h", p, isWr ? "write" : "read ", a, isWr ? d : refMem[a]);
    end
    readyMode = 0;
    checks++;
    if (obsWr.size() != expWr.size()) begin
      errors++;
      $display("FAIL rand_wr_count: got %0d strobes, required %0d", obsWr.size(), expWr.size());
    end
    for (int i = 0; i < expWr.size() && i < obsWr.size(); i++) begin
      checks++;
      if (obsWr[i] !== expWr[i]) begin
        errors++;
        $display("FAIL rand_write%0d: got %h required %h", i, obsWr[i], expWr[i]);
      end
    end
    checks++;
    if (obsTx.size() != expTx.size()) begin
      errors++;
      $display("FAIL rand_tx_count: got %0d bytes, required %0d", obsTx.size(), expTx.size());
    end
    for (int i = 0; i < expTx.size() && i < obsTx.size(); i++) begin
      checks++;
      if (obsTx[i] !== expTx[i]) begin
        errors++;
        $display("FAIL rand_tx%0d: got %h required %h", i, obsTx[i], expTx[i]);
      end
    end
  endtask

  initial begin
    memSeed = $urandom;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_timeout();
    test_junk();
    test_reset_mid_response();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_register_master.md
Name: stream_register_master

Overview:
Bus initiator for the memory-mapped register block. It parses command packets from an incoming byte stream, with the byte receiver upstream, and issues single register writes or reads on the 8-bit address / 32-bit data register bus. Each read produces a response packet on an outgoing byte stream with a valid/ready handshake, toward the byte transmitter. It sits between the byte-link PHY and the register block.

Parameters:
TIMEOUT, 50000, idle clocks allowed between bytes inside a packet before the parser aborts.
RD_LATENCY, 1, clocks from a stable opAddress to valid ipRdData.

Ports:
ipClk  in  1  clock
Reset  in  1  synchronous active-high reset
ipRxData  in  8  received byte
ipRxValid  in  1  one-cycle strobe per received byte; no backpressure
opTxData  out  8  response byte
opTxValid  out  1  response byte valid
ipTxReady  in  1  transmitter accepts byte when opTxValid & ipTxReady
opAddress  out  8  register address
opWrData  out  32  register write data
opWrEnable  out  1  one-cycle write strobe
ipRdData  in  32  register read data
opBusy  out  1  high outside Idle/header-parse states; Rx bytes are dropped while high

Behaviour:
- Reset: synchronous, active-high, named Reset; clock ipClk. On reset all outputs go to 0 and the FSM goes to Idle, including mid-packet and mid-response. opTxValid deasserts in the cycle after Reset is sampled.
- Request packet: 0x55 sync, cmd (0x00 read, 0x01 write), address, then for writes 4 data bytes, little-endian.
- Response packet (reads only): 0xAA, address, 4 data bytes, little-endian. Writes are not acknowledged.
- FSM states: Idle, Cmd, Addr, WrData, WrStrobe, RdWait, TxHeader, TxAddr, TxData.
- Idle: only 0x55 advances to Cmd. Any other byte is ignored.
- Cmd: 0x00 or 0x01 advances to Addr. Any other byte returns to Idle.
- Addr: latch opAddress. Write goes to WrData with byte count 0. Read goes to RdWait.
- WrData: shift bytes into opWrData, LSB first. After the 4th byte go to WrStrobe.
- WrStrobe: opWrEnable=1 for exactly one cycle, then Idle. opAddress and opWrData stay stable during the strobe and hold afterwards.
- RdWait: opAddress is held stable. Wait RD_LATENCY+1 cycles, then capture ipRdData into the response buffer and go to TxHeader.
- Tx states: drive opTxValid=1 with opTxData held stable until ipTxReady. Advance one byte per accepted transfer. After the 4th data byte, go to Idle with opTxValid=0 in the next cycle. Back-to-back transfers are allowed at one byte per clock when ipTxReady stays high.
- Timeout: the counter clears on every ipRxValid. In Cmd, Addr or WrData, reaching TIMEOUT with no byte returns the FSM to Idle and discards the partial packet; no write occurs. The counter is inactive in other states.
- A Rx byte arriving in the same cycle as timeout expiry is processed as Idle input.
- Rx bytes arriving in WrStrobe, RdWait or Tx states are dropped (opBusy=1).
- The byte counter is 2 bits and wraps only by explicit clear on state entry.
- opWrEnable is never asserted during a read.

Decomposition:
- Shared package: SYNC_REQ=8'h55, SYNC_RSP=8'hAA, CMD_READ=8'h00, CMD_WRITE=8'h01, FSM state enum.
- Sub-module response_serialiser: loads address and 32-bit data, then emits 6 bytes under valid/ready and reports done.
- Parser, timeout and bus sequencing stay in the top module.

Test Plan:
- Write: Rx 55 01 02 EF BE AD DE -> exactly one opWrEnable pulse with opAddress=0x02 and opWrData=0xDEADBEEF; no Tx activity.
- Read: Rx 55 00 01 with the model returning 0x0000000A at address 0x01 after a 1-cycle latency -> Tx AA 01 0A 00 00 00; opWrEnable stays 0.
- Backpressure: during a read response hold ipTxReady low for 10 cycles at each byte -> opTxData/opTxValid stable throughout; byte order unchanged; opBusy=1.
- Timeout (TIMEOUT=20): Rx 55 01 02 EF then 21 idle cycles -> no write. A subsequent full write packet executes correctly.
- Junk filtering: Rx 12 55 07 33 55 01 03 01 00 00 00 -> single write of 0x00000001 to address 0x03.
- Reset mid-response: assert Reset after the 2nd Tx byte is accepted -> opTxValid=0 next cycle; FSM in Idle; next read packet returns a complete 6-byte response.
